demosaic_mhc: RTL and testbench
===============================

# demosaic_mhc

Parametrised Bayer-to-RGB interpolator for the AHB ISP pipeline. It takes a pre-buffered 13-pixel diamond window centred on the current raw pixel and produces full RGB per pixel. Interpolation is either Malvar-He-Cutler (MHC, gradient-corrected) or plain bilinear. Unlike the earlier demosaic stage, it tracks the Bayer phase internally from frame/line counters, supports all four CFA orders, keeps a valid pipeline that tolerates bubbles, and reports framing errors.

## Interface
- DATA_W, 8: raw and output component width; must be ≥ 6.
- IMG_W, 640: active pixels per line.
- IMG_H, 480: active lines per frame.

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  window valid this cycle
- in_sof  in  1  first pixel of frame; qualified by in_valid
- win_pix  in  13*DATA_W  window; slice k = [(k+1)*DATA_W-1 : k*DATA_W], k=0..12 = p13,p22,p23,p24,p31,p32,p33,p34,p35,p42,p43,p44,p53 (row,col of 5x5; p33 = centre C)
- cfg_pattern  in  2  00 RGGB, 01 GRBG, 10 GBRG, 11 BGGR
- cfg_mode  in  1  0 MHC, 1 bilinear
- err_clr  in  1  clears err
- out_valid  out  1  RGB valid
- out_sof / out_eol  out  1  first pixel of frame / last pixel of line, aligned to out_valid
- out_r, out_g, out_b  out  DATA_W  components
- out_rgb565  out  16  {out_r[DATA_W-1-:5], out_g[DATA_W-1-:6], out_b[DATA_W-1-:5]}
- err  out  2  sticky; bit0 = pixel outside frame dropped, bit1 = early in_sof (frame restarted)

## Operation
- FSM: IDLE, ACTIVE.
  - IDLE: in_valid&in_sof → ACTIVE, col=0, row=0, latch cfg_pattern/cfg_mode.
  - IDLE: in_valid without in_sof → pixel dropped (no out_valid), err[0] set.
  - ACTIVE: each in_valid advances col.
  - col==IMG_W-1 → col=0, row++, out_eol tagged on that pixel.
  - col==IMG_W-1 && row==IMG_H-1 → IDLE after that pixel.
  - ACTIVE: in_valid&in_sof when not at col0/row0 → err[1] set; restart as from IDLE, with new cfg latched.
- cfg_* changes outside an accepted in_sof are ignored.
- Site from {row[0],col[0]} for RGGB: 00 R, 01 Gr, 10 Gb, 11 B. Other patterns XOR the indices: GRBG flips col, GBRG flips row, BGGR flips both.
- MHC kernel weights (×2, each kernel sums to 16). N,S,E,W = p23,p43,p34,p32; NN,SS,EE,WW = p13,p53,p35,p31; diagonals = p22,p24,p42,p44.
  - G at R/B: 8C +4(N,S,E,W) −2(NN,SS,EE,WW).
  - Horizontal kernel: 10C +8(W,E) −2(WW,EE) −2(diag) +1(NN,SS). Vertical kernel is the same with axes swapped.
  - R/B at B/R: 12C +4(diag) −3(NN,SS,EE,WW).
  - At Gr: R uses horizontal, B uses vertical. At Gb: B uses horizontal, R uses vertical.
- Bilinear kernels:
  - G at R/B: (N+S+E+W+2)>>2.
  - Horizontal: (W+E+1)>>1.
  - Vertical: (N+S+1)>>1.
  - Diagonal: (Σdiag+2)>>2.
- Native component is C unchanged.
- Arithmetic:
  - Signed accumulator, DATA_W+7 bits, no overflow.
  - MHC result = (sum+8)>>>4.
  - Clamp to [0, 2^DATA_W−1].
- No backpressure. Bubbles propagate through the pipeline unchanged.

## Timing
- Latency is exactly 3 cycles, in_valid@N → out_valid@N+3.
  - S1: site decode, weighted partial sums.
  - S2: final sum and rounding.
  - S3: clamp and mux into output registers.
- out_r/g/b/rgb565 hold their last value while out_valid=0.
- out_sof/out_eol are asserted only together with out_valid.
- err bits set at the S1 edge of the offending pixel.
  - err_clr clears err.
  - A set condition in the same cycle as err_clr wins (bit remains 1).
- Reset: on a clock edge with rst_n=0, all of the following are 0, and pipeline contents are discarded:
  - FSM=IDLE, counters, latched cfg.
  - Every output: out_valid, out_sof, out_eol, out_r, out_g, out_b, out_rgb565, err.
- Reset mid-frame: out_valid=0 from the first post-reset cycle. The first valid output after reset requires a new in_sof.
- in_valid may toggle every cycle; full throughput is 1 pixel/cycle.

## Test plan
- Flat field, all 13 pixels = 100, RGGB, MHC, 8 px streamed → each output R=G=B=100, out_valid exactly 3 cycles after each in_valid.
- MHC, DATA_W=8, at Gr site, C=255, all other pixels 0 → R=B=159 (2550+8)>>4, G=255. At R site, C=0, NN/SS/EE/WW=255, others 0 → G clamps to 0. At B site, C=255, diagonals 255, others 0 → R=255 (clamp of 446).
- IMG_W=4, IMG_H=2, BGGR, ramp input → site order B,Gb,B,Gb / Gr,R,Gr,R. out_eol on pixels 3 and 7, out_sof on pixel 0. A 9th in_valid without in_sof → no output, err=01.
- Random in_valid gaps (≈50% duty) over one frame → out_valid sequence equals in_valid delayed 3 cycles. Pixel count is IMG_W*IMG_H.
- in_sof at row 1 col 2 with cfg_pattern changed GRBG→GBRG → err=10, counters restart, new site order. err_clr with no new error → err=00.
- cfg_mode=1, site R, N=S=E=W=10, diagonals=20 → G=10, B=20, R=C. Assert rst_n=0 mid-frame → all outputs 0 the next cycle, no out_valid until a new in_sof.

Source files
------------

// File: rtl/demosaic_mhc_if.sv
// Stream bundle for demosaic_mhc: 13-pixel diamond window in, RGB pixel out.
interface demosaic_mhc_if #(
    parameter int unsigned DATA_W = 8
);
    logic                 in_valid;
    logic                 in_sof;
    logic [13*DATA_W-1:0] win_pix;
    logic                 out_valid;
    logic                 out_sof;
    logic                 out_eol;
    logic [DATA_W-1:0]    out_r;
    logic [DATA_W-1:0]    out_g;
    logic [DATA_W-1:0]    out_b;
    logic [15:0]          out_rgb565;

    modport master (
        output in_valid, in_sof, win_pix,
        input  out_valid, out_sof, out_eol, out_r, out_g, out_b, out_rgb565
    );
    modport slave (
        input  in_valid, in_sof, win_pix,
        output out_valid, out_sof, out_eol, out_r, out_g, out_b, out_rgb565
    );
endinterface

// File: rtl/demosaic_mhc.sv
// Bayer-to-RGB interpolator (Malvar-He-Cutler or bilinear) with internal phase tracking,
// 3-stage valid pipeline and sticky framing errors.
module demosaic_mhc #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned IMG_H  = 480
) (
    input  logic          clk,
    input  logic          rst_n,
    demosaic_mhc_if.slave bus,
    input  logic [1:0]    cfg_pattern,
    input  logic          cfg_mode,
    input  logic          err_clr,
    output logic [1:0]    err
);
    localparam int unsigned AccW = DATA_W + 7;
    localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

    typedef logic signed [AccW-1:0] acc_t;
    typedef enum logic [0:0] {StIdle, StActive} state_e;

    function automatic acc_t ext(input logic [DATA_W-1:0] v);
        return acc_t'({7'b0, v});
    endfunction

    function automatic acc_t rnd(input acc_t a, input int unsigned sh);
        acc_t bias;
        bias = acc_t'(1) <<< (sh - 1);
        return (a + bias) >>> sh;
    endfunction

    function automatic logic [DATA_W-1:0] clamp(input acc_t a);
        if (a[AccW-1]) return '0;
        if (|a[AccW-2:DATA_W]) return '1;
        return a[DATA_W-1:0];
    endfunction

    state_e          state_q, state_d;
    logic [ColW-1:0] col_q, col_d, pix_col;
    logic [RowW-1:0] row_q, row_d, pix_row;
    logic [1:0]      pattern_q, pattern_d, pix_pattern, pix_site, err_q, err_d;
    logic            mode_q, mode_d, pix_mode, take_sof, accept, pix_eol;

    // A pixel carrying in_sof always starts a frame at (0,0) with the freshly presented cfg.
    assign take_sof    = bus.in_valid & bus.in_sof;
    assign accept      = take_sof | (bus.in_valid & (state_q == StActive));
    assign pix_col     = take_sof ? '0 : col_q;
    assign pix_row     = take_sof ? '0 : row_q;
    assign pix_pattern = take_sof ? cfg_pattern : pattern_q;
    assign pix_mode    = take_sof ? cfg_mode : mode_q;
    assign pix_eol     = (pix_col == ColLast);
    assign pix_site    = {pix_row[0] ^ pix_pattern[1], pix_col[0] ^ pix_pattern[0]};

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        pattern_d = pattern_q;
        mode_d    = mode_q;
        err_d     = err_clr ? 2'b00 : err_q;
        if (bus.in_valid && !bus.in_sof && state_q == StIdle) err_d[0] = 1'b1;
        if (take_sof && state_q == StActive && (col_q != '0 || row_q != '0)) err_d[1] = 1'b1;
        if (take_sof) begin
            pattern_d = cfg_pattern;
            mode_d    = cfg_mode;
        end
        if (accept) begin
            state_d = StActive;
            row_d   = pix_row;
            col_d   = pix_col + ColW'(1);
            if (pix_eol) begin
                col_d = '0;
                if (pix_row == RowLast) begin
                    row_d   = '0;
                    state_d = StIdle;
                end else begin
                    row_d = pix_row + RowW'(1);
                end
            end
        end
    end

    // S1 kernels: MHC weights are x2 (sum 16); bilinear keeps plain neighbour sums.
    acc_t c, we, ns, wwee, nnss, dsum, acc_g, acc_h, acc_v, acc_d;
    always_comb begin
        c    = ext(bus.win_pix[6*DATA_W +: DATA_W]);
        we   = ext(bus.win_pix[5*DATA_W +: DATA_W]) + ext(bus.win_pix[7*DATA_W +: DATA_W]);
        ns   = ext(bus.win_pix[2*DATA_W +: DATA_W]) + ext(bus.win_pix[10*DATA_W +: DATA_W]);
        wwee = ext(bus.win_pix[4*DATA_W +: DATA_W]) + ext(bus.win_pix[8*DATA_W +: DATA_W]);
        nnss = ext(bus.win_pix[0 +: DATA_W]) + ext(bus.win_pix[12*DATA_W +: DATA_W]);
        dsum = ext(bus.win_pix[1*DATA_W +: DATA_W]) + ext(bus.win_pix[3*DATA_W +: DATA_W])
             + ext(bus.win_pix[9*DATA_W +: DATA_W]) + ext(bus.win_pix[11*DATA_W +: DATA_W]);
        if (pix_mode) begin
            acc_g = we + ns;
            acc_h = we;
            acc_v = ns;
            acc_d = dsum;
        end else begin
            acc_g = (c <<< 3) + ((we + ns) <<< 2) - ((wwee + nnss) <<< 1);
            acc_h = (c <<< 3) + (c <<< 1) + (we <<< 3) - (wwee <<< 1) - (dsum <<< 1) + nnss;
            acc_v = (c <<< 3) + (c <<< 1) + (ns <<< 3) - (nnss <<< 1) - (dsum <<< 1) + wwee;
            acc_d = (c <<< 3) + (c <<< 2) + (dsum <<< 2) - ((wwee + nnss) <<< 1) - (wwee + nnss);
        end
    end

    logic              s1_valid, s1_sof, s1_eol, s1_mode;
    logic [1:0]        s1_site;
    logic [DATA_W-1:0] s1_c;
    acc_t              s1_g, s1_h, s1_v, s1_d;

    // S2: rounding, then route kernels to components by CFA site.
    acc_t g_k, h_k, v_k, d_k, c_k, r_n, g_n, b_n;
    always_comb begin
        g_k = s1_mode ? rnd(s1_g, 2) : rnd(s1_g, 4);
        h_k = s1_mode ? rnd(s1_h, 1) : rnd(s1_h, 4);
        v_k = s1_mode ? rnd(s1_v, 1) : rnd(s1_v, 4);
        d_k = s1_mode ? rnd(s1_d, 2) : rnd(s1_d, 4);
        c_k = ext(s1_c);
        r_n = c_k;
        g_n = g_k;
        b_n = d_k;
        case (s1_site)
            2'b01:   begin r_n = h_k; g_n = c_k; b_n = v_k; end
            2'b10:   begin r_n = v_k; g_n = c_k; b_n = h_k; end
            2'b11:   begin r_n = d_k; g_n = g_k; b_n = c_k; end
            default: begin r_n = c_k; g_n = g_k; b_n = d_k; end
        endcase
    end

    logic              s2_valid, s2_sof, s2_eol;
    acc_t              s2_r, s2_g, s2_b;
    logic [DATA_W-1:0] r_c, g_c, b_c, r_q, g_q, b_q;
    logic [15:0]       rgb565_q;
    logic              out_valid_q, out_sof_q, out_eol_q;

    assign r_c = clamp(s2_r);
    assign g_c = clamp(s2_g);
    assign b_c = clamp(s2_b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            col_q <= '0; row_q <= '0; pattern_q <= '0; mode_q <= 1'b0; err_q <= '0;
            s1_valid <= 1'b0; s1_sof <= 1'b0; s1_eol <= 1'b0; s1_mode <= 1'b0;
            s1_site <= '0; s1_c <= '0; s1_g <= '0; s1_h <= '0; s1_v <= '0; s1_d <= '0;
            s2_valid <= 1'b0; s2_sof <= 1'b0; s2_eol <= 1'b0;
            s2_r <= '0; s2_g <= '0; s2_b <= '0;
            out_valid_q <= 1'b0; out_sof_q <= 1'b0; out_eol_q <= 1'b0;
            r_q <= '0; g_q <= '0; b_q <= '0; rgb565_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            pattern_q <= pattern_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
            s1_valid  <= accept;
            s1_sof    <= take_sof;
            s1_eol    <= accept & pix_eol;
            s1_mode   <= pix_mode;
            s1_site   <= pix_site;
            s1_c      <= bus.win_pix[6*DATA_W +: DATA_W];
            s1_g      <= acc_g;
            s1_h      <= acc_h;
            s1_v      <= acc_v;
            s1_d      <= acc_d;
            s2_valid  <= s1_valid;
            s2_sof    <= s1_sof;
            s2_eol    <= s1_eol;
            s2_r      <= r_n;
            s2_g      <= g_n;
            s2_b      <= b_n;
            out_valid_q <= s2_valid;
            out_sof_q   <= s2_valid & s2_sof;
            out_eol_q   <= s2_valid & s2_eol;
            if (s2_valid) begin
                r_q      <= r_c;
                g_q      <= g_c;
                b_q      <= b_c;
                rgb565_q <= {r_c[DATA_W-1 -: 5], g_c[DATA_W-1 -: 6], b_c[DATA_W-1 -: 5]};
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_sof    = out_sof_q;
    assign bus.out_eol    = out_eol_q;
    assign bus.out_r      = r_q;
    assign bus.out_g      = g_q;
    assign bus.out_b      = b_q;
    assign bus.out_rgb565 = rgb565_q;
    assign err            = err_q;
endmodule

// File: tb/tb_demosaic_mhc.sv
// Directed bench for demosaic_mhc on a 4x2 frame: kernels, CFA phase, framing errors, reset.
module tb_demosaic_mhc;
    localparam int unsigned DW = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] cfg_pattern;
    logic       cfg_mode;
    logic       err_clr;
    logic [1:0] err;
    int         checks = 0;
    int         errors = 0;

    demosaic_mhc_if #(.DATA_W(DW)) bus ();

    demosaic_mhc #(.DATA_W(DW), .IMG_W(4), .IMG_H(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .cfg_pattern(cfg_pattern),
        .cfg_mode(cfg_mode), .err_clr(err_clr), .err(err)
    );

    always #5 clk = ~clk;

    // BGGR ramp, window C=v, W=E=16, rest 0: sites B,Gb,B,Gb,Gr,R,Gr,R.
    int bg_r [8] = '{6, 10, 18, 20, 41, 48, 51, 64};
    int bg_g [8] = '{12, 16, 20, 32, 40, 32, 56, 40};
    int bg_b [8] = '{8, 26, 24, 36, 25, 36, 35, 48};
    // Early-sof run, C=32, W=E=16: Gr,R,Gr,R,B,Gb then restart as GBRG: Gb,B,Gb,B.
    logic [1:0] es_pat [10] = '{2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0};
    int es_r [10] = '{36, 32, 36, 32, 24, 20, 20, 24, 20, 24};
    int es_g [10] = '{32, 24, 32, 24, 24, 32, 32, 24, 32, 24};
    int es_b [10] = '{20, 24, 20, 24, 32, 36, 36, 32, 36, 32};

    function automatic logic [13*DW-1:0] mk_win(input logic [7:0] c, n, s, e, w,
                                                input logic [7:0] nn, ss, ee, ww, d);
        return {ss, d, s, d, ee, e, c, w, ww, d, n, d, nn};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sof, input logic [13*DW-1:0] w);
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.win_pix  = w;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rgb(input string tag, input int r, input int g, input int b);
        check({tag, "_r"}, 32'(bus.out_r), r);
        check({tag, "_g"}, 32'(bus.out_g), g);
        check({tag, "_b"}, 32'(bus.out_b), b);
    endtask

    // One sof pixel, then wait until it reaches the outputs.
    task automatic run_one(input logic [1:0] pat, input logic mode, input logic [13*DW-1:0] w);
        cfg_pattern = pat;
        cfg_mode    = mode;
        drive(1'b1, 1'b1, w);
        tick();
        drive(1'b0, 1'b0, w);
        tick();
        tick();
        check("one_valid", 32'(bus.out_valid), 1);
    endtask

    initial begin
        logic [13*DW-1:0] flat;
        logic [13*DW-1:0] w;
        logic [2:0]       vh;
        logic             v;
        int               sent;
        int               got;

        flat = mk_win(8'd100, 8'd100, 8'd100, 8'd100, 8'd100,
                      8'd100, 8'd100, 8'd100, 8'd100, 8'd100);
        rst_n = 1'b0; cfg_pattern = 2'd0; cfg_mode = 1'b0; err_clr = 1'b0;
        drive(1'b0, 1'b0, '0);
        tick();
        tick();
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_err", 32'(err), 0);
        check("rst_565", 32'(bus.out_rgb565), 0);
        rst_n = 1'b1;

        // Flat field RGGB MHC: every component 100, exactly 3 cycles of latency.
        for (int i = 0; i < 11; i++) begin
            drive(i < 8, i == 0, flat);
            tick();
            check("flat_valid", 32'(bus.out_valid), 32'(i >= 2 && i < 10));
            if (i >= 2 && i < 10) begin
                check_rgb("flat", 100, 100, 100);
                check("flat_565", 32'(bus.out_rgb565), 25388);
                check("flat_sof", 32'(bus.out_sof), 32'(i == 2));
                check("flat_eol", 32'(bus.out_eol), 32'(i == 5 || i == 9));
            end
        end
        check("flat_err", 32'(err), 0);

        // BGGR ramp frame: site order and framing tags.
        cfg_pattern = 2'd3;
        for (int i = 0; i < 11; i++) begin
            w = mk_win(8'(8 * i + 8), 8'd0, 8'd0, 8'd16, 8'd16, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
            drive(i < 8, i == 0, w);
            tick();
            check("bggr_valid", 32'(bus.out_valid), 32'(i >= 2 && i < 10));
            if (i >= 2 && i < 10) begin
                check_rgb($sformatf("bggr%0d", i - 2), bg_r[i-2], bg_g[i-2], bg_b[i-2]);
                check("bggr_sof", 32'(bus.out_sof), 32'(i == 2));
                check("bggr_eol", 32'(bus.out_eol), 32'(i == 5 || i == 9));
            end
        end

        // Stray pixel after the frame ends is dropped and flagged.
        drive(1'b1, 1'b0, flat);
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(1'b0, 1'b0, flat);
            check("stray_valid", 32'(bus.out_valid), 0);
        end
        check("stray_err", 32'(err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_err", 32'(err), 0);

        // Random bubbles: out_valid is in_valid delayed by 3 cycles.
        cfg_pattern = 2'd0;
        sent = 0; got = 0; vh = '0;
        for (int k = 0; k < 60; k++) begin
            v = (sent < 8) && ($urandom_range(0, 1) == 1);
            drive(v, v && sent == 0, flat);
            if (v) sent++;
            tick();
            check("gap_valid", 32'(bus.out_valid), 32'(vh[1]));
            vh = {vh[1:0], v};
            if (bus.out_valid) got++;
        end
        check("gap_count", got, 8);
        check("gap_err", 32'(err), 0);

        // Early sof at row 1 col 2 restarts with newly latched GBRG.
        w = mk_win(8'd32, 8'd0, 8'd0, 8'd16, 8'd16, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 12; i++) begin
            cfg_pattern = (i < 10) ? es_pat[i] : 2'd0;
            drive(i < 10, i == 0 || i == 6, w);
            tick();
            check("early_err", 32'(err), (i >= 6) ? 2 : 0);
            if (i >= 2) begin
                check_rgb($sformatf("early%0d", i - 2), es_r[i-2], es_g[i-2], es_b[i-2]);
                check("early_sof", 32'(bus.out_sof), 32'(i == 2 || i == 8));
                check("early_eol", 32'(bus.out_eol), 32'(i == 5 || i == 11));
            end
        end
        drive(1'b0, 1'b0, w);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("early_clr", 32'(err), 0);

        // Single-pixel kernel checks, site chosen through the CFA order.
        run_one(2'd1, 1'b0, mk_win(8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
        check_rgb("mhc_gr", 159, 255, 159);
        run_one(2'd0, 1'b0, mk_win(8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                                   8'd255, 8'd255, 8'd255, 8'd255, 8'd0));
        check_rgb("mhc_r_neg", 0, 0, 0);
        run_one(2'd3, 1'b0, mk_win(8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255));
        check_rgb("mhc_b_sat", 255, 128, 255);
        check("mhc_b_565", 32'(bus.out_rgb565), 64543);
        run_one(2'd2, 1'b0, mk_win(8'd0, 8'd0, 8'd0, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
        check_rgb("mhc_gb_hv", 0, 0, 100);
        run_one(2'd0, 1'b1, mk_win(8'd50, 8'd10, 8'd10, 8'd10, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd20));
        check_rgb("bil_r", 50, 10, 20);
        run_one(2'd1, 1'b1, mk_win(8'd90, 8'd1, 8'd2, 8'd8, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
        check_rgb("bil_gr", 8, 90, 2);

        // Reset mid-frame clears everything; output resumes only after a new sof.
        cfg_pattern = 2'd0;
        cfg_mode    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i == 0, flat);
            tick();
        end
        rst_n = 1'b0;
        tick();
        check("mrst_valid", 32'(bus.out_valid), 0);
        check_rgb("mrst", 0, 0, 0);
        check("mrst_565", 32'(bus.out_rgb565), 0);
        check("mrst_sofeol", 32'({bus.out_sof, bus.out_eol}), 0);
        check("mrst_err", 32'(err), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, flat);
            tick();
            check("mrst_novalid", 32'(bus.out_valid), 0);
        end
        check("mrst_drop_err", 32'(err), 1);
        drive(1'b1, 1'b1, flat);
        tick();
        drive(1'b0, 1'b0, flat);
        tick();
        check("mrst_wait", 32'(bus.out_valid), 0);
        tick();
        check("mrst_resume", 32'(bus.out_valid), 1);
        check("mrst_resume_r", 32'(bus.out_r), 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
